// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline types for the RV32 front end: data width, the canonical NOP,
// the fetch FSM state encoding and the next-PC select codes.
// Optional build macro IFU_MISALIGN_TRAP_EN adds the FAULT fetch state.
package rv32_pipe_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    VALID,
    DROP
`ifdef IFU_MISALIGN_TRAP_EN
    , FAULT
`endif
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD,
    NPC_INCR,
    NPC_BRANCH,
    NPC_RESET
  } npc_sel_e;

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select for the fetch unit: reset vector, redirect target,
// sequential PC+4 (wraps modulo 2^32) or hold.
module ifu_next_pc
  import rv32_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  npc_sel_e        sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_plus_four,
  output logic [XLEN-1:0] next_pc
);

  // Kept separate from the mux so the incrementer has no dependency on sel.
  assign pc_plus_four = pc + 32'd4;

  // Pick the PC for the next cycle.
  always_comb begin
    next_pc = pc;
    case (sel)
      NPC_RESET:  next_pc = RESET_PC;
      NPC_BRANCH: next_pc = branch_target;
      NPC_INCR:   next_pc = pc_plus_four;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from IMEM, presents
// it to IF/ID with its PC, honours STALL and redirects on BRANCH_TAKEN.
// A redirect while a read is outstanding parks in DROP until the stale word
// returns. Build macro IFU_MISALIGN_TRAP_EN adds MISALIGN_FAULT and a sticky
// FAULT state for redirects to non-word-aligned targets.
module instruction_fetch_unit
  import rv32_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            IMEM_READ,
  output logic [XLEN-1:0] IMEM_ADDRESS,
  input  logic [XLEN-1:0] IMEM_READDATA,
  input  logic            IMEM_BUSYWAIT,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_PLUS_FOUR_OUT,
  output logic [XLEN-1:0] INSTRUCTION_OUT,
  output logic            BUSYWAIT
`ifdef IFU_MISALIGN_TRAP_EN
  , output logic          MISALIGN_FAULT
`endif
);

  fetch_state_e    state_q, state_d;
  npc_sel_e        sel;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus_four, br_tgt;
  logic            imem_read_q, imem_read_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d, pc4_q, pc4_d, instr_q, instr_d;
`ifdef IFU_MISALIGN_TRAP_EN
  logic            fault_q, fault_d;
  // Misaligned targets trap instead of fetching, so the target passes as-is.
  assign br_tgt = BRANCH_TARGET;
`else
  // No trap: the low two bits are simply ignored.
  assign br_tgt = BRANCH_TARGET & ~32'h3;
`endif

  ifu_next_pc #(.RESET_PC(RESET_PC)) u_next_pc (
    .sel           (sel),
    .pc            (pc_q),
    .branch_target (br_tgt),
    .pc_plus_four  (pc_plus_four),
    .next_pc       (pc_d)
  );

  // Fetch FSM next state, PC select and IF/ID output latching; redirect wins.
  always_comb begin
    state_d  = state_q;
    sel      = NPC_HOLD;
    pc_out_d = pc_out_q;
    pc4_d    = pc4_q;
    instr_d  = instr_q;
`ifdef IFU_MISALIGN_TRAP_EN
    fault_d  = fault_q;
`endif
    if (RESET) begin
      state_d = IDLE;
      sel     = NPC_RESET;
`ifdef IFU_MISALIGN_TRAP_EN
    end else if (state_q == FAULT) begin
      state_d = FAULT;
    end else if (BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00)) begin
      state_d = FAULT;
      fault_d = 1'b1;
`endif
    end else if (BRANCH_TAKEN) begin
      sel     = NPC_BRANCH;
      state_d = REQ;
      // An in-flight read must complete before the new address goes out.
      if ((state_q == REQ || state_q == DROP) && IMEM_BUSYWAIT) state_d = DROP;
      if (state_q != DROP) instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (!IMEM_BUSYWAIT) begin
            instr_d  = IMEM_READDATA;
            pc_out_d = pc_q;
            pc4_d    = pc_plus_four;
            state_d  = VALID;
          end
        end
        VALID: begin
          if (!STALL) begin
            sel     = NPC_INCR;
            state_d = REQ;
          end
        end
        DROP: if (!IMEM_BUSYWAIT) state_d = REQ;
        default: state_d = state_q;
      endcase
    end
  end

  // Memory request follows the next state; DROP keeps the stale address.
  always_comb begin
    imem_read_d = (state_d == REQ) || (state_d == DROP);
    imem_addr_d = (state_d == REQ) ? pc_d : imem_addr_q;
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_read_q <= 1'b0;
      imem_addr_q <= '0;
      pc_out_q    <= '0;
      pc4_q       <= '0;
      instr_q     <= NOP_INSTR;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_read_q <= imem_read_d;
      imem_addr_q <= imem_addr_d;
      pc_out_q    <= pc_out_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  assign IMEM_READ        = imem_read_q;
  assign IMEM_ADDRESS     = imem_addr_q;
  assign PC_OUT           = pc_out_q;
  assign PC_PLUS_FOUR_OUT = pc4_q;
  assign INSTRUCTION_OUT  = instr_q;
  assign BUSYWAIT         = (state_q != VALID) | STALL;
`ifdef IFU_MISALIGN_TRAP_EN
  assign MISALIGN_FAULT   = fault_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized
// stall/busy/redirect/reset traffic against a program-order reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1, STALL = 1'b0, BRANCH_TAKEN = 1'b0, IMEM_BUSYWAIT = 1'b0;
  logic [31:0] BRANCH_TARGET = '0, IMEM_READDATA = '0;
  logic        IMEM_READ, BUSYWAIT;
  logic [31:0] IMEM_ADDRESS, PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        MISALIGN_FAULT;
`endif

  instruction_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .STALL            (STALL),
    .BRANCH_TAKEN     (BRANCH_TAKEN),
    .BRANCH_TARGET    (BRANCH_TARGET),
    .IMEM_READ        (IMEM_READ),
    .IMEM_ADDRESS     (IMEM_ADDRESS),
    .IMEM_READDATA    (IMEM_READDATA),
    .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
    .PC_OUT           (PC_OUT),
    .PC_PLUS_FOUR_OUT (PC_PLUS_FOUR_OUT),
    .INSTRUCTION_OUT  (INSTRUCTION_OUT),
    .BUSYWAIT         (BUSYWAIT)
`ifdef IFU_MISALIGN_TRAP_EN
    , .MISALIGN_FAULT (MISALIGN_FAULT)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0, n_err = 0, n_cons = 0;
  logic [31:0] exp_pc = RST_PC;     // PC of the next instruction IF/ID should accept
  bit          faulted = 1'b0;
  bit          rst_chk = 1'b0;
  bit          prev_rb = 1'b0;      // a read was pending (busy) at the last edge
  logic [31:0] prev_addr = '0;

  // Instruction memory contents: a fixed hash of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, check outputs, then advance
  // the model by what the following rising edge does.
  task automatic drive(input bit rst, input bit stall, input bit br,
                       input logic [31:0] tgt, input bit busy);
    @(negedge CLK);
    RESET = rst; STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
    IMEM_BUSYWAIT = busy;
    IMEM_READDATA = busy ? 32'hBAD0_BAD0 : mem(IMEM_ADDRESS);
    #1;
    if (rst_chk) begin
      chk("rst_pc_out", PC_OUT, 32'h0);
      chk("rst_pc4", PC_PLUS_FOUR_OUT, 32'h0);
      chk("rst_instr", INSTRUCTION_OUT, NOP);
      chk("rst_read", IMEM_READ, 1'b0);
      chk("rst_busy", BUSYWAIT, 1'b1);
    end
    if (prev_rb) begin
      chk("hold_read", IMEM_READ, 1'b1);
      chk("hold_addr", IMEM_ADDRESS, prev_addr);
    end
`ifdef IFU_MISALIGN_TRAP_EN
    chk("fault_flag", MISALIGN_FAULT, faulted);
    if (faulted) chk("fault_read", IMEM_READ, 1'b0);
`endif
    if (!BUSYWAIT) begin
      n_cons++;
      chk("cons_pc", PC_OUT, exp_pc);
      chk("cons_pc4", PC_PLUS_FOUR_OUT, exp_pc + 32'd4);
      chk("cons_instr", INSTRUCTION_OUT, mem(exp_pc));
      chk("cons_read", IMEM_READ, 1'b0);
    end
    prev_rb   = !rst && IMEM_READ && busy;
    prev_addr = IMEM_ADDRESS;
    rst_chk   = rst;
    if (rst) begin
      exp_pc  = RST_PC;
      faulted = 1'b0;
    end else begin
      if (!BUSYWAIT) exp_pc = exp_pc + 32'd4;
      if (br && !faulted) begin
`ifdef IFU_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) faulted = 1'b1;
        else exp_pc = tgt;
`else
        exp_pc = tgt & ~32'h3;
`endif
      end
    end
  endtask

  initial begin
    logic [31:0] t;

    // Zero-wait streaming: one instruction every second cycle from 0x0.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 9; o++) begin
      drive(0, 0, 0, 0, 0);
      chk("a_busy", BUSYWAIT, (o == 3 || o == 5 || o == 7 || o == 9) ? 1'b0 : 1'b1);
      if (o == 2 || o == 4 || o == 6) chk("a_addr", IMEM_ADDRESS, 32'((o - 2) * 2));
    end

    // Memory busy for three cycles on the fetch at 0x4.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 8; o++) begin
      drive(0, 0, 0, 0, (o >= 4 && o <= 6));
      if (o >= 4 && o <= 6) begin
        chk("b_read", IMEM_READ, 1'b1);
        chk("b_addr", IMEM_ADDRESS, 32'h4);
        chk("b_busy", BUSYWAIT, 1'b1);
      end
      if (o == 7) chk("b_busy7", BUSYWAIT, 1'b1);
      if (o == 8) chk("b_pc", PC_OUT, 32'h4);
    end

    // Hazard stall for four cycles while 0x8 is presented.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 12; o++) begin
      drive(0, (o >= 7 && o <= 10), 0, 0, 0);
      if (o >= 7 && o <= 10) begin
        chk("c_busy", BUSYWAIT, 1'b1);
        chk("c_read", IMEM_READ, 1'b0);
        chk("c_pc", PC_OUT, 32'h8);
        chk("c_instr", INSTRUCTION_OUT, mem(32'h8));
      end
      if (o == 11) chk("c_rel", BUSYWAIT, 1'b0);
      if (o == 12) chk("c_addr", IMEM_ADDRESS, 32'hC);
    end

    // Redirect to 0x100 while the fetch at 0x10 is still busy.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 14; o++) begin
      drive(0, 0, (o == 10), 32'h100, (o == 10 || o == 11));
      if (o >= 10 && o <= 12) begin
        chk("d_read", IMEM_READ, 1'b1);
        chk("d_stale_addr", IMEM_ADDRESS, 32'h10);
        chk("d_busy", BUSYWAIT, 1'b1);
      end
      if (o == 13) chk("d_addr", IMEM_ADDRESS, 32'h100);
      if (o == 14) begin
        chk("d_pres", BUSYWAIT, 1'b0);
        chk("d_pc", PC_OUT, 32'h100);
        chk("d_pc4", PC_PLUS_FOUR_OUT, 32'h104);
      end
    end

    // PC wrap from the top of the address space.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 6; o++) begin
      drive(0, 0, (o == 3), 32'hFFFF_FFFC, 0);
      if (o == 4) chk("e_addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
      if (o == 5) chk("e_pc4", PC_PLUS_FOUR_OUT, 32'h0);
      if (o == 6) chk("e_wrap", IMEM_ADDRESS, 32'h0);
    end

    // Redirect to a misaligned target 0x102.
    drive(1, 0, 0, 0, 0);
    for (int o = 1; o <= 8; o++) begin
      drive(0, 0, (o == 3), 32'h102, 0);
`ifdef IFU_MISALIGN_TRAP_EN
      if (o >= 4) begin
        chk("f_fault", MISALIGN_FAULT, 1'b1);
        chk("f_read", IMEM_READ, 1'b0);
        chk("f_busy", BUSYWAIT, 1'b1);
      end
`else
      if (o == 4) chk("f_addr", IMEM_ADDRESS, 32'h100);
      if (o == 5) chk("f_pc", PC_OUT, 32'h100);
`endif
    end

    // Randomized traffic checked against the program-order model.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      t = $urandom_range(0, 1023) << 2;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
`ifndef IFU_MISALIGN_TRAP_EN
      t = t | $urandom_range(0, 3);
`endif
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0, t, $urandom_range(0, 2) == 0);
    end
    chk("liveness", (n_cons > 300), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), placed on INSTRUCTION_OUT when no valid fetch exists.
REQ-003 SHALL use one clock; reset synchronous, active-high.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 STALL  in  1  hazard-unit hold; instruction not consumed.
REQ-007 BRANCH_TAKEN  in  1  redirect request from EX, single-cycle pulse.
REQ-008 BRANCH_TARGET  in  32  redirect byte address.
REQ-009 IMEM_READ  out  1  instruction memory read request.
REQ-010 IMEM_ADDRESS  out  32  byte address of fetch.
REQ-011 IMEM_READDATA  in  32  fetched word, valid when IMEM_BUSYWAIT=0 with IMEM_READ=1.
REQ-012 IMEM_BUSYWAIT  in  1  memory not ready.
REQ-013 PC_OUT  out  32  PC of presented instruction (to IF_ID PC_IN).
REQ-014 PC_PLUS_FOUR_OUT  out  32  PC_OUT+4 (to IF_ID PC_PLUS_FOUR_IN).
REQ-015 INSTRUCTION_OUT  out  32  presented instruction (to IF_ID INSTRUCTION_IN).
REQ-016 BUSYWAIT  out  1  IF_ID hold; high unless a valid instruction is presented and STALL=0.

Function
REQ-017 FSM states SHALL be IDLE, REQ, VALID, DROP (plus FAULT per REQ-031).
REQ-018 IDLE: IMEM_READ=0; next edge -> REQ.
REQ-019 REQ: IMEM_READ=1, IMEM_ADDRESS=PC, held stable; stay while IMEM_BUSYWAIT=1.
REQ-020 REQ with IMEM_BUSYWAIT=0: at edge latch INSTRUCTION_OUT=IMEM_READDATA, PC_OUT=PC, PC_PLUS_FOUR_OUT=PC+4; -> VALID.
REQ-021 VALID: IMEM_READ=0; BUSYWAIT=STALL; at edge with STALL=0, PC<=PC+4, -> REQ; with STALL=1 hold all outputs.
REQ-022 BUSYWAIT SHALL be combinational: (state!=VALID) | STALL.
REQ-023 Min latency: 2 cycles per instruction at zero memory wait; each instruction presented exactly once.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-025 BRANCH_TAKEN SHALL have priority over STALL and sequential advance.
REQ-026 Branch in IDLE, VALID, or REQ with IMEM_BUSYWAIT=0: PC<=BRANCH_TARGET, INSTRUCTION_OUT<=NOP_INSTR, -> REQ; read data discarded.
REQ-027 Branch in REQ with IMEM_BUSYWAIT=1: PC<=BRANCH_TARGET, -> DROP; DROP keeps IMEM_READ=1 at old address until IMEM_BUSYWAIT=0, discards data, -> REQ.
REQ-028 Branch in DROP: PC<=new BRANCH_TARGET, remain DROP.

Reset
REQ-029 RESET (any state, incl. mid-fetch) at edge: PC=RESET_PC, state IDLE, IMEM_READ=0, PC_OUT=0, PC_PLUS_FOUR_OUT=0, INSTRUCTION_OUT=NOP_INSTR, BUSYWAIT=1; outstanding fetch abandoned.
REQ-030 RESET SHALL override BRANCH_TAKEN and STALL.

Configuration
REQ-031 Macro IFU_MISALIGN_TRAP_EN defined: output MISALIGN_FAULT (1 bit, reset 0) added; BRANCH_TAKEN with BRANCH_TARGET[1:0]!=0 -> FAULT state, MISALIGN_FAULT=1 sticky, IMEM_READ=0, BUSYWAIT=1 until RESET.
REQ-032 Macro undefined: no MISALIGN_FAULT port, no FAULT state; BRANCH_TARGET[1:0] forced to 2'b00.

Structure
REQ-033 Package rv32_pipe_pkg SHALL hold XLEN=32, NOP_INSTR value, fetch-state enum.
REQ-034 One sub-module ifu_next_pc (combinational next-PC select: RESET_PC / BRANCH_TARGET / PC+4 / hold) SHALL be used.

Verification
REQ-035 Reset, IMEM_BUSYWAIT=0, STALL=0 -> fetches at 0x0,0x4,0x8; INSTRUCTION_OUT valid, BUSYWAIT low every 2nd cycle.
REQ-036 IMEM_BUSYWAIT high 3 cycles at 0x4 -> IMEM_ADDRESS=0x4 stable, BUSYWAIT=1 throughout, then 0x4 word presented once.
REQ-037 STALL=1 for 4 cycles in VALID at PC 0x8 -> outputs held, no IMEM_READ, next fetch 0xC after release.
REQ-038 BRANCH_TAKEN target 0x100 during busy fetch at 0x10 -> DROP, stale word discarded, next presented PC_OUT=0x100, PC_PLUS_FOUR_OUT=0x104.
REQ-039 PC 0xFFFFFFFC consumed -> next fetch address 0x00000000.
REQ-040 With IFU_MISALIGN_TRAP_EN, target 0x102 -> MISALIGN_FAULT=1, IMEM_READ=0 until RESET; without, fetch from 0x100.
